// File: rtl/dff_chain_pkg.sv
// Shared types and sizing helpers for the flip-flop chain sequencer.
package dff_chain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter width able to hold WIDTH+DEPTH without wrapping.
    function automatic int cnt_w(input int width, input int depth);
        return $clog2(width + depth + 1);
    endfunction

endpackage

// File: rtl/dff_chain_ctrl_chain.sv
// Serial chain of master-slave D flip-flops with per-stage stuck-at-0 injection.
module d_master_slave (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic stuck0,
    output logic q
);

    logic q_r;

    // Master-slave pair: the value present before the rising edge appears at q after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= 1'b0;
        end else begin
            q_r <= d;
        end
    end

    assign q = q_r & ~stuck0;

endmodule

module dff_chain #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic [DEPTH-1:0] stuck0,
    output logic             q
);

    logic [DEPTH:0] link_s;

    assign link_s[0] = d;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        d_master_slave u_stage (
            .clk    (clk),
            .rst    (rst),
            .d      (link_s[i]),
            .stuck0 (stuck0[i]),
            .q      (link_s[i+1])
        );
    end

    assign q = link_s[DEPTH];

endmodule

// File: rtl/dff_chain_ctrl.sv
// Loopback sequencer: clears the chain, shifts a word in MSB first and
// captures it at the tail, reporting whether the round trip was intact.
module dff_chain_ctrl
    import dff_chain_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] word_in,
    input  logic             chain_q,
    output logic             chain_d,
    output logic             chain_rst,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] word_out,
    output logic             match
);

    localparam int CW = cnt_w(WIDTH, DEPTH);

    localparam logic [CW-1:0] CNT_ZERO      = CW'(0);
    localparam logic [CW-1:0] CNT_ONE       = CW'(1);
    localparam logic [CW-1:0] CNT_FIRST_CAP = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_TX_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_LAST      = CW'(WIDTH + DEPTH - 1);

    // Bit of v sent at position idx (MSB first); out-of-range positions read 0.
    function automatic logic pick_bit(input logic [WIDTH-1:0] v, input logic [CW-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx == CW'(i)) begin
                b = v[WIDTH-1-i];
            end else begin
                b = b;
            end
        end
        return b;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nxt_s;
    logic [CW-1:0]    tx_idx_s;
    logic [WIDTH-1:0] tx_reg_r;
    logic [WIDTH-1:0] tx_nxt_s;
    logic [WIDTH-1:0] rx_reg_r;
    logic [WIDTH-1:0] rx_nxt_s;
    logic [WIDTH-1:0] rx_shift_s;
    logic             tx_bit_s;
    logic             chain_d_nxt_s;
    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic             word_upd_s;

    if (WIDTH == 1) begin : g_rx_one
        assign rx_shift_s = chain_q;
    end else begin : g_rx_many
        assign rx_shift_s = {rx_reg_r[WIDTH-2:0], chain_q};
    end

    // The bit driven next cycle: MSB when leaving CLEAR, otherwise position cnt+1.
    assign tx_idx_s  = (state_r == SHIFT) ? (cnt_r + CNT_ONE) : CNT_ZERO;
    assign tx_bit_s  = pick_bit(tx_reg_r, tx_idx_s);
    assign chain_rst = rst | (state_r == CLEAR);

    // Next-state, counter, shift-register and output-register decode.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        tx_nxt_s      = tx_reg_r;
        rx_nxt_s      = rx_reg_r;
        chain_d_nxt_s = 1'b0;
        busy_nxt_s    = 1'b0;
        done_nxt_s    = 1'b0;
        word_upd_s    = 1'b0;

        case (state_r)
            IDLE: begin
                if (start) begin
                    tx_nxt_s    = word_in;
                    state_nxt_s = CLEAR;
                    busy_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                    busy_nxt_s  = 1'b0;
                end
            end
            CLEAR: begin
                cnt_nxt_s     = CNT_ZERO;
                state_nxt_s   = SHIFT;
                busy_nxt_s    = 1'b1;
                chain_d_nxt_s = tx_bit_s;
            end
            SHIFT: begin
                busy_nxt_s = 1'b1;
                if (cnt_r >= CNT_FIRST_CAP) begin
                    rx_nxt_s = rx_shift_s;
                end else begin
                    rx_nxt_s = rx_reg_r;
                end
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s   = DONE;
                    done_nxt_s    = 1'b1;
                    word_upd_s    = 1'b1;
                    chain_d_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                    if (cnt_r < CNT_TX_LAST) begin
                        chain_d_nxt_s = tx_bit_s;
                    end else begin
                        chain_d_nxt_s = 1'b0;
                    end
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
                busy_nxt_s  = 1'b0;
            end
            default: begin
                state_nxt_s = IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs; reset aborts without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            tx_reg_r <= {WIDTH{1'b0}};
            rx_reg_r <= {WIDTH{1'b0}};
            chain_d  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            word_out <= {WIDTH{1'b0}};
            match    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            tx_reg_r <= tx_nxt_s;
            rx_reg_r <= rx_nxt_s;
            chain_d  <= chain_d_nxt_s;
            busy     <= busy_nxt_s;
            done     <= done_nxt_s;
            if (word_upd_s) begin
                word_out <= rx_nxt_s;
                match    <= (rx_nxt_s == tx_reg_r);
            end else begin
                word_out <= word_out;
                match    <= match;
            end
        end
    end

endmodule

// File: tb/tb_dff_chain_ctrl.sv
// Loopback bench: controller driving a 4-stage chain, checked against a
// transfer-level model of the expected bit stream, timing and result.
module tb_dff_chain_ctrl;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int LATENCY = 2 + WIDTH + DEPTH;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] word_in;
    logic             chain_q;
    logic             chain_d;
    logic             chain_rst;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] word_out;
    logic             match;
    logic [DEPTH-1:0] stuck0;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int done_cyc = 0;

    dff_chain_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .word_in   (word_in),
        .chain_q   (chain_q),
        .chain_d   (chain_d),
        .chain_rst (chain_rst),
        .busy      (busy),
        .done      (done),
        .word_out  (word_out),
        .match     (match)
    );

    dff_chain #(.DEPTH(DEPTH)) u_chain (
        .clk    (clk),
        .rst    (chain_rst),
        .d      (chain_d),
        .stuck0 (stuck0),
        .q      (chain_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete transfer from IDLE; stage < 0 means a healthy chain.
    task automatic do_transfer(input logic [WIDTH-1:0] w, input int stage);
        logic [WIDTH-1:0] exp_w;
        int ev;
        if (stage >= 0) begin
            stuck0 = DEPTH'(1 << stage);
            exp_w  = '0;
        end else begin
            stuck0 = '0;
            exp_w  = w;
        end
        start   = 1'b1;
        word_in = w;
        tick();
        start   = 1'b0;
        word_in = WIDTH'($urandom);
        check("clear_chain_rst", chain_rst, 1);
        check("clear_busy", busy, 1);
        check("clear_chain_d", chain_d, 0);
        for (int i = 0; i < WIDTH + DEPTH; i++) begin
            tick();
            ev = (i < WIDTH) ? ((int'(w) >> (WIDTH - 1 - i)) & 1) : 0;
            check("shift_chain_d", chain_d, ev);
            check("shift_no_done", done, 0);
            check("shift_chain_rst", chain_rst, 0);
        end
        tick();
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_word_out", word_out, exp_w);
        check("done_match", match, (exp_w == w));
        done_cyc = cyc;
        tick();
        check("after_done", done, 0);
        check("after_busy", busy, 0);
        check("after_word_held", word_out, exp_w);
    endtask

    initial begin
        int first_done;
        logic [WIDTH-1:0] w2;
        int gap;
        int stage;

        rst     = 1'b1;
        start   = 1'b0;
        word_in = '0;
        stuck0  = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_chain_rst", chain_rst, 1);
        check("rst_word_out", word_out, 0);
        check("rst_match", match, 0);
        check("rst_chain_d", chain_d, 0);
        rst = 1'b0;
        tick();
        check("idle_chain_rst", chain_rst, 0);

        do_transfer(8'hA5, -1);
        do_transfer(8'hA5, 2);
        stuck0 = '0;

        // Start held high with word_in toggling every cycle.
        start   = 1'b1;
        word_in = 8'h0F;
        tick();
        for (int k = 1; k < LATENCY; k++) begin
            word_in = (word_in == 8'h0F) ? 8'hF0 : 8'h0F;
            tick();
        end
        check("hold_done1", done, 1);
        check("hold_word1", word_out, 8'h0F);
        check("hold_match1", match, 1);
        first_done = cyc;
        word_in = (word_in == 8'h0F) ? 8'hF0 : 8'h0F;
        tick();
        check("hold_idle_busy", busy, 0);
        word_in = (word_in == 8'h0F) ? 8'hF0 : 8'h0F;
        w2 = word_in;
        tick();
        check("hold_restart_busy", busy, 1);
        check("hold_restart_clear", chain_rst, 1);
        for (int k = 1; k < LATENCY; k++) begin
            word_in = (word_in == 8'h0F) ? 8'hF0 : 8'h0F;
            tick();
        end
        check("hold_done2", done, 1);
        check("hold_word2", word_out, w2);
        check("hold_match2", match, 1);
        check("hold_spacing", cyc - first_done, LATENCY + 1);
        start = 1'b0;
        tick();
        tick();
        check("hold_stopped", busy, 0);

        // Reset during SHIFT at cnt=5.
        start   = 1'b1;
        word_in = 8'h99;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        rst = 1'b1;
        #1;
        check("midrst_chain_rst", chain_rst, 1);
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_word_out", word_out, 0);
        check("midrst_match", match, 0);
        check("midrst_chain_d", chain_d, 0);
        for (int k = 0; k < LATENCY; k++) begin
            tick();
            check("midrst_no_done", done, 0);
        end
        do_transfer(8'h3C, -1);

        // Boundary words back to back.
        do_transfer(8'h00, -1);
        first_done = done_cyc;
        do_transfer(8'hFF, -1);
        check("b2b_spacing", done_cyc - first_done, LATENCY + 1);

        // Random words, gaps and occasional stuck stages.
        for (int n = 0; n < 10; n++) begin
            gap = int'($urandom_range(0, 2));
            for (int k = 0; k < gap; k++) tick();
            stage = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : -1;
            do_transfer(WIDTH'($urandom), stage);
        end
        stuck0 = '0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
